// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, ALU control encoding and
// the payloads held in the execute and result registers.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_OP  = 2'b00,
    ALU_BR  = 2'b01,
    ALU_ADD = 2'b10
  } alu_ctrl_e;

  // Execute-register payload; target is zero for anything but a branch.
  typedef struct packed {
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] instr;
    alu_ctrl_e       ctrl;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_br;
    logic [XLEN-1:0] target;
    logic            illegal;
  } exe_pl_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            rd_we;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            illegal;
  } wb_pl_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational operand/immediate/control generation for one incoming
// instruction; the result is what the execute register captures on accept.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output exe_pl_t     pl_o
);

  logic [2:0]  funct3;
  logic        rd_nz;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;

  assign funct3 = instr_i[14:12];
  assign rd_nz  = |instr_i[11:7];
  assign imm_i  = sext12(instr_i[31:20]);
  assign imm_s  = sext12({instr_i[31:25], instr_i[11:7]});
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                   instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};

  always_comb begin
    pl_o       = '0;
    pl_o.instr = instr_i;
    pl_o.rd    = instr_i[11:7];
    pl_o.ctrl  = ALU_ADD;
    case (instr_i[6:0])
      OP_R: begin
        pl_o.src_a = rs1_i;
        pl_o.src_b = rs2_i;
        pl_o.ctrl  = ALU_OP;
        pl_o.rd_we = rd_nz;
      end
      OP_I: begin
        pl_o.src_a = rs1_i;
        pl_o.ctrl  = ALU_OP;
        pl_o.rd_we = rd_nz;
        // The ALU only decodes R-type, so I-type is presented as R-type.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          pl_o.src_b = {27'b0, instr_i[24:20]};
          pl_o.instr = {instr_i[31:7], OP_R};
        end else begin
          // Clear funct7 so an immediate with bit 30 set can't select SUB.
          pl_o.src_b = imm_i;
          pl_o.instr = {7'b0, instr_i[24:7], OP_R};
        end
      end
      OP_BR: begin
        pl_o.src_a  = rs1_i;
        pl_o.src_b  = rs2_i;
        pl_o.ctrl   = ALU_BR;
        pl_o.is_br  = 1'b1;
        pl_o.target = pc_i + imm_b;
      end
      OP_LD: begin
        pl_o.src_a = rs1_i;
        pl_o.src_b = imm_i;
      end
      OP_ST: begin
        pl_o.src_a = rs1_i;
        pl_o.src_b = imm_s;
      end
      OP_LUI: begin
        pl_o.src_b = imm_u;
        pl_o.rd_we = rd_nz;
      end
      OP_AUIPC: begin
        pl_o.src_a = pc_i;
        pl_o.src_b = imm_u;
        pl_o.rd_we = rd_nz;
      end
      default: pl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-register issue stage: E drives the combinational ALU, W captures its
// result for writeback/redirect; valid/ready on both sides, 1 instr/cycle.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [XLEN-1:0] src_A,
  output logic [XLEN-1:0] src_B,
  output logic [XLEN-1:0] instruction,
  output logic [1:0]      ALU_control,
  input  logic [XLEN-1:0] ALU_result,
  input  logic            BranchConditionFlag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_branch_taken,
  output logic [XLEN-1:0] out_branch_target,
  output logic            out_illegal
);

  exe_pl_t dec_pl, e_q;
  wb_pl_t  w_q, w_d;
  logic    e_v_q, e_v_d, w_v_q, w_v_d;
  logic    w_accept, e_adv, in_fire;

  alu_issue_decode u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .rs1_i   (in_rs1),
    .rs2_i   (in_rs2),
    .pl_o    (dec_pl)
  );

  assign w_accept = ~w_v_q | out_ready;
  assign e_adv    = e_v_q & w_accept;
  // Held low while in reset so every output reads zero during reset.
  assign in_ready = n_rst & (~e_v_q | w_accept);
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    e_v_d = e_v_q;
    if (in_fire)    e_v_d = 1'b1;
    else if (e_adv) e_v_d = 1'b0;

    w_v_d = w_v_q;
    if (e_adv)                  w_v_d = 1'b1;
    else if (w_v_q & out_ready) w_v_d = 1'b0;

    w_d.result  = ALU_result;
    w_d.rd      = e_q.rd;
    w_d.rd_we   = e_q.rd_we;
    w_d.taken   = e_q.is_br & BranchConditionFlag;
    w_d.target  = e_q.target;
    w_d.illegal = e_q.illegal;
  end

  // Payloads only load on their handshake; E keeps driving the ALU when idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      e_v_q <= 1'b0;
      w_v_q <= 1'b0;
      e_q   <= '0;
      w_q   <= '0;
    end else begin
      e_v_q <= e_v_d;
      w_v_q <= w_v_d;
      if (in_fire) e_q <= dec_pl;
      if (e_adv)   w_q <= w_d;
    end
  end

  assign src_A             = e_q.src_a;
  assign src_B             = e_q.src_b;
  assign instruction       = e_q.instr;
  assign ALU_control       = e_q.ctrl;

  assign out_valid         = w_v_q;
  assign out_result        = w_q.result;
  assign out_rd            = w_q.rd;
  assign out_rd_we         = w_q.rd_we;
  assign out_branch_taken  = w_q.taken;
  assign out_branch_target = w_q.target;
  assign out_illegal       = w_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU downstream, ISA-level reference
// model fed at accept time, scoreboard compared at every output handshake.
module tb_alu_issue_stage;

  logic        clk, n_rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
  logic [31:0] src_A, src_B, instruction;
  logic [1:0]  ALU_control;
  logic [31:0] ALU_result;
  logic        BranchConditionFlag;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_branch_target;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_branch_taken, out_illegal;

  alu_issue_stage dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_instr            (in_instr),
    .in_pc               (in_pc),
    .in_rs1              (in_rs1),
    .in_rs2              (in_rs2),
    .src_A               (src_A),
    .src_B               (src_B),
    .instruction         (instruction),
    .ALU_control         (ALU_control),
    .ALU_result          (ALU_result),
    .BranchConditionFlag (BranchConditionFlag),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_result          (out_result),
    .out_rd              (out_rd),
    .out_rd_we           (out_rd_we),
    .out_branch_taken    (out_branch_taken),
    .out_branch_target   (out_branch_target),
    .out_illegal         (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the team ALU: decodes R-type funct3/funct7[5], compares for branches.
  always_comb begin
    ALU_result          = '0;
    BranchConditionFlag = 1'b0;
    case (ALU_control)
      2'b00: case (instruction[14:12])
        3'd0: ALU_result = instruction[30] ? src_A - src_B : src_A + src_B;
        3'd1: ALU_result = src_A << src_B[4:0];
        3'd2: ALU_result = {31'b0, $signed(src_A) < $signed(src_B)};
        3'd3: ALU_result = {31'b0, src_A < src_B};
        3'd4: ALU_result = src_A ^ src_B;
        3'd5: ALU_result = instruction[30] ? 32'($signed(src_A) >>> src_B[4:0])
                                           : src_A >> src_B[4:0];
        3'd6: ALU_result = src_A | src_B;
        default: ALU_result = src_A & src_B;
      endcase
      2'b01: begin
        ALU_result = src_A - src_B;
        case (instruction[14:12])
          3'd0: BranchConditionFlag = (src_A == src_B);
          3'd1: BranchConditionFlag = (src_A != src_B);
          3'd4: BranchConditionFlag = ($signed(src_A) < $signed(src_B));
          3'd5: BranchConditionFlag = ($signed(src_A) >= $signed(src_B));
          3'd6: BranchConditionFlag = (src_A < src_B);
          3'd7: BranchConditionFlag = (src_A >= src_B);
          default: BranchConditionFlag = 1'b0;
        endcase
      end
      default: ALU_result = src_A + src_B;
    endcase
  end

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        taken;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  exp_t exq[$];
  int   n_cmp = 0, n_err = 0, n_acc = 0, n_out = 0;
  bit   rdone;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] isa_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  // Architectural view: what each RV32I instruction should produce.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [2:0]  f3;
    logic [31:0] ii, is_, ib, iu;
    f3  = ins[14:12];
    ii  = {{20{ins[31]}}, ins[31:20]};
    is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu  = {ins[31:12], 12'b0};
    e.res = '0; e.rd = ins[11:7]; e.we = 1'b0; e.taken = 1'b0; e.tgt = '0; e.ill = 1'b0;
    case (ins[6:0])
      7'h33: begin e.res = isa_op(f3, ins[30] && (f3 == 0 || f3 == 5), a, b); e.we = |ins[11:7]; end
      7'h13: begin e.res = isa_op(f3, ins[30] && f3 == 5, a, ii); e.we = |ins[11:7]; end
      7'h63: begin
        e.res = a - b;
        e.tgt = pc + ib;
        case (f3)
          3'd0: e.taken = (a == b);
          3'd1: e.taken = (a != b);
          3'd4: e.taken = ($signed(a) < $signed(b));
          3'd5: e.taken = ($signed(a) >= $signed(b));
          3'd6: e.taken = (a < b);
          3'd7: e.taken = (a >= b);
          default: e.taken = 1'b0;
        endcase
      end
      7'h03: e.res = a + ii;
      7'h23: e.res = a + is_;
      7'h37: begin e.res = iu; e.we = |ins[11:7]; end
      7'h17: begin e.res = pc + iu; e.we = |ins[11:7]; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    r  = $urandom;
    f3 = r[14:12];
    case ($urandom_range(0, 7))
      0: begin r[31:25] = ((f3 == 0 || f3 == 5) && r[30]) ? 7'h20 : 7'h00; r[6:0] = 7'h33; end
      1: begin
        if (f3 == 1) r[31:25] = 7'h00;
        else if (f3 == 5) r[31:25] = r[30] ? 7'h20 : 7'h00;
        r[6:0] = 7'h13;
      end
      2: begin if (f3 == 2 || f3 == 3) r[14:12] = 3'd0; r[6:0] = 7'h63; end
      3: r[6:0] = 7'h03;
      4: r[6:0] = 7'h23;
      5: r[6:0] = 7'h37;
      6: r[6:0] = 7'h17;
      default: case ($urandom_range(0, 3))
        0: r[6:0] = 7'h7F;
        1: r[6:0] = 7'h0F;
        2: r[6:0] = 7'h73;
        default: r[6:0] = 7'h00;
      endcase
    endcase
    return r;
  endfunction

  // Scoreboard: handshakes sampled mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (n_rst) begin
      if (out_valid && out_ready) begin
        exp_t e;
        n_out++;
        chk("out_has_expected", 32'(exq.size() != 0), 1);
        if (exq.size() != 0) begin
          e = exq.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_rd_we", 32'(out_rd_we), 32'(e.we));
          chk("out_taken", 32'(out_branch_taken), 32'(e.taken));
          chk("out_target", out_branch_target, e.tgt);
          chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exq.push_back(ref_model(in_instr, in_pc, in_rs1, in_rs2));
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    in_rs1   = a;
    in_rs2   = b;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(got), 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 200 && exq.size() != 0; c++) step();
    repeat (2) step();
    chk("drain_empty", 32'(exq.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_out;
    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rdone = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_src_A", src_A, 0);
    chk("rst_ctrl", 32'(ALU_control), 0);
    chk("rst_out_result", out_result, 0);
    n_rst = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 1);
    step();

    // ADDI x3,x1,-1
    send(32'hFFF08193, 32'h0, 32'd10, 32'h0);
    chk("addi_src_A", src_A, 32'd10);
    chk("addi_src_B", src_B, 32'hFFFFFFFF);
    chk("addi_ctrl", 32'(ALU_control), 0);
    chk("addi_f7", 32'(instruction[31:25]), 0);
    step();
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_result", out_result, 32'd9);
    chk("addi_rd", 32'(out_rd), 3);
    chk("addi_we", 32'(out_rd_we), 1);

    // BLT x1,x2,+16 at pc 0x100
    send(32'h0020C863, 32'h100, 32'hFFFFFFFB, 32'd2);
    chk("blt_ctrl", 32'(ALU_control), 1);
    step();
    chk("blt_taken", 32'(out_branch_taken), 1);
    chk("blt_target", out_branch_target, 32'h110);
    chk("blt_we", 32'(out_rd_we), 0);

    // SRAI x5,x1,4
    send(32'h4040D293, 32'h0, 32'hF0000000, 32'h0);
    chk("srai_bit30", 32'(instruction[30]), 1);
    chk("srai_src_B", src_B, 32'd4);
    step();
    chk("srai_result", out_result, 32'hFF000000);

    // AUIPC x1,0x12345 at pc 0xFFFFF000
    send(32'h12345097, 32'hFFFFF000, 32'h0, 32'h0);
    chk("auipc_ctrl", 32'(ALU_control), 2);
    step();
    chk("auipc_result", out_result, 32'h12344000);

    // Unsupported opcode 0x7F
    send(32'h0000057F, 32'h40, 32'd7, 32'd9);
    step();
    chk("ill_flag", 32'(out_illegal), 1);
    chk("ill_we", 32'(out_rd_we), 0);
    repeat (2) step();

    // Back-to-back ADDs with downstream stalled for three cycles
    base_acc = n_acc; base_out = n_out;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++)
        send({7'h00, 5'(i + 2), 5'(i + 1), 3'b000, 5'(i + 10), 7'h33},
             32'h0, 32'($urandom), 32'($urandom));
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_accepts", 32'(n_acc - base_acc), 2);
        out_ready = 1'b1;
      end
    join
    repeat (6) step();
    chk("stall_outputs", 32'(n_out - base_out), 4);

    // Reset asserted with two instructions in flight
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'h11, 32'h22);
    send(32'h00A00093, 32'h0, 32'h33, 32'h44);
    #2 n_rst = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_src_A", src_A, 0);
    chk("mrst_src_B", src_B, 0);
    chk("mrst_instr", instruction, 0);
    chk("mrst_out_result", out_result, 0);
    chk("mrst_rd_we", 32'(out_rd_we), 0);
    chk("mrst_in_ready", 32'(in_ready), 0);
    exq.delete();
    base_out = n_out;
    @(negedge clk);
    n_rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    chk("mrst_no_output", 32'(out_valid), 0);
    chk("mrst_out_count", 32'(n_out - base_out), 0);
    chk("mrst_in_ready_back", 32'(in_ready), 1);

    // Randomized stream with random downstream back-pressure and input gaps
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          send(gen_instr(), $urandom & 32'hFFFFFFFC,
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
        end
        rdone = 1'b1;
      end
      while (!rdone) begin
        step();
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU operand interface.
- Accepts decoded-stage instructions (instruction, PC, register operands) over a valid/ready handshake and registers them into an execute register. That register drives src_A, src_B, instruction and ALU_control into the combinational ALU.
- Captures ALU_result and BranchConditionFlag into a result register presented downstream over a second valid/ready handshake.
- Sits between register-file read and writeback/PC-redirect logic in the team CPU.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  stage accepts this cycle
- in_instr  input  32  raw RV32I instruction
- in_pc  input  32  instruction PC
- in_rs1  input  32  rs1 register value
- in_rs2  input  32  rs2 register value
- src_A  output  32  ALU operand A (registered)
- src_B  output  32  ALU operand B (registered)
- instruction  output  32  instruction word presented to ALU (registered, possibly rewritten)
- ALU_control  output  2  00 = R/I op, 01 = branch compare, 10 = forced add (registered)
- ALU_result  input  32  ALU result, combinational from src_A/src_B/instruction/ALU_control
- BranchConditionFlag  input  1  ALU branch condition
- out_valid  output  1  result register valid
- out_ready  input  1  downstream accepts
- out_result  output  32  captured ALU_result
- out_rd  output  5  destination register
- out_rd_we  output  1  writeback enable
- out_branch_taken  output  1  branch resolved taken
- out_branch_target  output  32  pc + B-immediate (branches only, else 0)
- out_illegal  output  1  unsupported opcode

Behaviour:
- Reset (async, n_rst=0): every output 0; in_ready=1 after reset release.
- Pipeline valid bits:
  - e_v is the execute-register valid bit; w_v is the result-register valid bit.
  - w_accept = !w_v | out_ready.
  - in_ready = !e_v | w_accept.
- Execute register (E):
  - Loads on in_valid & in_ready.
  - e_v clears when E advances (e_v & w_accept) with no new accept.
  - ALU outputs hold their last value while e_v=0.
- Result register (W):
  - Loads on e_v & w_accept, capturing ALU_result and BranchConditionFlag that same cycle.
  - w_v clears on out_valid & out_ready with no new load.
- Latency and throughput:
  - Accept at edge k → ALU inputs valid after k, out_valid after k+1.
  - Throughput 1 instruction/cycle.
  - out_ready=0 stalls W, then E, then in_ready=0. No data is lost or duplicated.
- Decode at accept, by opcode in_instr[6:0]:
  - 0110011 R: A=rs1, B=rs2, ctrl=00, instruction unchanged, rd_we = (rd!=0).
  - 0010011 I:
    - A=rs1, ctrl=00, rd_we = (rd!=0).
    - funct3 001/101: B={27'b0, instr[24:20]}, instruction keeps [31:25].
    - Other funct3: B=sext(instr[31:20]), instruction [31:25] forced 0 so a set imm bit 30 cannot select SUB.
    - In all I cases, the opcode presented to the ALU is rewritten to 0110011.
  - 1100011 branch: A=rs1, B=rs2, ctrl=01, rd_we=0, target=pc+sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 0000011 load: A=rs1, B=sext I-imm, ctrl=10, rd_we=0.
  - 0100011 store: A=rs1, B=sext S-imm, ctrl=10, rd_we=0.
  - 0110111 LUI: A=0, B={instr[31:12],12'b0}, ctrl=10, rd_we = (rd!=0).
  - 0010111 AUIPC: A=pc, B=U-imm, ctrl=10, rd_we = (rd!=0).
  - Any other opcode: A=B=0, ctrl=10, rd_we=0, illegal=1.
  - ctrl 11 is never driven.
- out_branch_taken = BranchConditionFlag only when the W instruction is a branch, else 0.
- All address and immediate arithmetic is mod 2^32 and wraps silently.
- Reset mid-operation: both stages are flushed immediately and in-flight instructions are discarded.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants (OP_R, OP_I, OP_BR, OP_LD, OP_ST, OP_LUI, OP_AUIPC).
  - ALU_control enum (ALU_OP, ALU_BR, ALU_ADD).
  - Stage payload struct.
- One sub-module, alu_issue_decode: purely combinational immediate/operand/ctrl generation. The top holds both pipeline registers and the handshake logic.
- The bench instantiates the existing ALU downstream of this stage.

Test Plan:
- ADDI x3,x1,-1 with rs1=10, out_ready=1 → src_B=0xFFFFFFFF, ALU_control=00, instruction[31:25]=0; two cycles later out_result=9, out_rd=3, out_rd_we=1.
- BLT with rs1=-5, rs2=2, pc=0x100, imm=+16 → ALU_control=01, out_branch_taken=1, out_branch_target=0x110, out_rd_we=0.
- Back-to-back stream of 4 R-type ADDs, out_ready held 0 for 3 cycles → in_ready drops after 2 accepts; on release, 4 results emerge in order, none dropped or repeated.
- SRAI x5,x1,4 with rs1=0xF0000000 → instruction[30]=1, src_B=4, out_result=0xFF000000.
- Opcode 0x7F → out_illegal=1, out_rd_we=0; assert n_rst low mid-stream → all outputs 0 asynchronously, out_valid=0 until a new accept.
- AUIPC x1,0x12345 at pc=0xFFFFF000 → ALU_control=10, out_result=0x12344000 (wraps).
